// File: rtl/div_sequencer.sv
// Iterative 32-bit restoring divider (div/divu) with a fixed 32-step latency and flush abort.
// Optional DIV_ZERO_FAST_EN: zero divisor finishes in one cycle and raises dz during FIN.
module div_sequencer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
`ifdef DIV_ZERO_FAST_EN
    ,
    output logic        dz
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] rem_r, rem_s;
    logic [31:0] quo_r, quo_s;
    logic [31:0] dvs_r, dvs_s;
    logic [31:0] hi_r, hi_s;
    logic [31:0] lo_r, lo_s;
    logic [4:0]  cnt_r, cnt_s;
    logic        qneg_r, qneg_s;
    logic        rneg_r, rneg_s;
    logic        busy_r, done_r;
    logic [32:0] rem_sh_s;
    logic [31:0] diff_s;
    logic        accept_s;
    logic        zero_fast_s;

    function automatic logic [31:0] abs_f(input logic [31:0] v, input logic en);
        if (en && v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [31:0] neg_f(input logic [31:0] v, input logic en);
        if (en) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast_s = (divisor == 32'd0);
`else
    assign zero_fast_s = 1'b0;
`endif

    // Next-state, datapath step and result load.
    always_comb begin
        state_s  = state_r;
        rem_s    = rem_r;
        quo_s    = quo_r;
        dvs_s    = dvs_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        cnt_s    = cnt_r;
        qneg_s   = qneg_r;
        rneg_s   = rneg_r;
        accept_s = 1'b0;
        rem_sh_s = {1'b0, rem_r} << 1;
        rem_sh_s[0] = quo_r[31];
        diff_s   = rem_sh_s[31:0] - dvs_r;
        if (flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE, FIN: begin
                    if (start) begin
                        accept_s = 1'b1;
                        if (zero_fast_s) begin
                            state_s = FIN;
                            lo_s    = 32'hFFFF_FFFF;
                            hi_s    = dividend;
                        end else begin
                            state_s = CALC;
                            rem_s   = 32'd0;
                            quo_s   = abs_f(dividend, sign);
                            dvs_s   = abs_f(divisor, sign);
                            qneg_s  = sign & (dividend[31] ^ divisor[31]);
                            rneg_s  = sign & dividend[31];
                            cnt_s   = 5'd0;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                CALC: begin
                    // Remainder lives in rem_r, dividend bits shift out of quo_r's MSB.
                    if (rem_sh_s >= {1'b0, dvs_r}) begin
                        rem_s = diff_s;
                        quo_s = {quo_r[30:0], 1'b1};
                    end else begin
                        rem_s = rem_sh_s[31:0];
                        quo_s = {quo_r[30:0], 1'b0};
                    end
                    cnt_s = cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_s = FIN;
                        lo_s    = neg_f(quo_s, qneg_r);
                        hi_s    = neg_f(rem_s, rneg_r);
                    end else begin
                        state_s = CALC;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            rem_r   <= 32'd0;
            quo_r   <= 32'd0;
            dvs_r   <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            cnt_r   <= 5'd0;
            qneg_r  <= 1'b0;
            rneg_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            rem_r   <= rem_s;
            quo_r   <= quo_s;
            dvs_r   <= dvs_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            cnt_r   <= cnt_s;
            qneg_r  <= qneg_s;
            rneg_r  <= rneg_s;
            busy_r  <= (state_s == CALC);
            done_r  <= (state_s == FIN);
        end
    end

`ifdef DIV_ZERO_FAST_EN
    logic dz_r;

    // Zero-divisor flag accompanies only the short-path FIN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dz_r <= 1'b0;
        end else begin
            dz_r <= accept_s & zero_fast_s;
        end
    end

    assign dz = dz_r;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed corner cases plus randomized div/divu traffic.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rstn, start, sign, flush;
    logic [31:0] dividend, divisor;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef DIV_ZERO_FAST_EN
    logic        dz;
`endif

    div_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start), .sign(sign),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef DIV_ZERO_FAST_EN
        , .dz(dz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division with the ISA's zero and overflow rules.
    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b, input int k);
        exp_t e;
        e.cyc = k + 33;
        e.dz  = 1'b0;
        if (b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
`ifdef DIV_ZERO_FAST_EN
            e.cyc = k + 1;
            e.dz  = 1'b1;
`endif
        end else if (!s) begin
            e.lo = a / b;
            e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 32'd0;
        end else begin
            e.lo = $signed(a) / $signed(b);
            e.hi = $signed(a) % $signed(b);
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard on every done pulse, otherwise checks that results hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            model_hi = 32'd0;
            model_lo = 32'd0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("lo", lo, e.lo);
                chk("hi", hi, e.hi);
`ifdef DIV_ZERO_FAST_EN
                chk("dz", {31'd0, dz}, {31'd0, e.dz});
`endif
                model_hi = e.hi;
                model_lo = e.lo;
            end
        end else begin
            chk("hi_hold", hi, model_hi);
            chk("lo_hold", lo, model_lo);
`ifdef DIV_ZERO_FAST_EN
            chk("dz_idle", {31'd0, dz}, 32'd0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        sb.push_back(model(s, a, b, cyc));
        start = 1'b1; sign = s; dividend = a; divisor = b;
        step();
        start = 1'b0; sign = 1'($urandom); dividend = $urandom; divisor = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            chk("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        step();
    endtask

    initial begin
        logic        s;
        logic [31:0] a, b;
        rstn = 1'b0; start = 1'b0; sign = 1'b0; flush = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        repeat (3) step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rstn = 1'b1;

        // divu 100/7 with busy window checks
        issue(1'b0, 32'd100, 32'd7);
        chk("busy_first", {31'd0, busy}, 32'd1);
        repeat (31) step();
        chk("busy_last", {31'd0, busy}, 32'd1);
        step();
        chk("busy_fin", {31'd0, busy}, 32'd0);
        wait_idle();

        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        issue(1'b0, 32'h0000_1234, 32'd0);
        wait_idle();

        // flush mid-CALC, then restart two cycles after the flush cycle
        issue(1'b0, 32'd50, 32'd5);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        void'(sb.pop_back());
        chk("flush_busy", {31'd0, busy}, 32'd0);
        step();
        issue(1'b0, 32'd50, 32'd5);
        wait_idle();

        // flush and start together: start must be dropped
        flush = 1'b1; start = 1'b1; dividend = 32'd77; divisor = 32'd3;
        step();
        flush = 1'b0; start = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        repeat (3) step();

        // back-to-back: second start in the first one's FIN cycle
        issue(1'b0, 32'd9, 32'd3);
        repeat (32) step();
        chk("b2b_done", {31'd0, done}, 32'd1);
        issue(1'b0, 32'd10, 32'd4);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle();

        // async reset mid-operation, then start on the first edge after release
        issue(1'b0, 32'd1000, 32'd9);
        repeat (14) step();
        rstn = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        void'(sb.pop_back());
        step();
        step();
        rstn = 1'b1;
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_idle();

        // randomized traffic with stray starts during CALC
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (i == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
`ifndef DIV_ZERO_FAST_EN
            if (b == 32'd0) s = 1'b0;
`endif
            issue(s, a, b);
            if (sb[sb.size()-1].dz == 1'b0) begin
                repeat (3) step();
                start = 1'b1;
                step();
                start = 1'b0;
            end
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
